riscv_crypto_sha256_msched: RTL and testbench
=============================================

RISCV_CRYPTO_SHA256_MSCHED -- requirements
Module: riscv_crypto_sha256_msched

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits, matching the SHA-256 word size.
REQ-002 g_clk  input  1  global clock; all state updates on its rising edge.
REQ-003 g_resetn  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  synchronous abort; returns the block to LOAD.
REQ-005 in_valid  input  1  in_data holds a message word.
REQ-006 in_data  input  32  message word M[i], big-endian word order, i = 0..15.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 out_valid  output  1  out_data holds schedule word W[t].
REQ-009 out_data  output  32  schedule word W[t].
REQ-010 out_idx  output  6  t for the current out_data, 0..63.
REQ-011 out_last  output  1  high with out_valid when t == 63.
REQ-012 out_ready  input  1  consumer accepts W[t] this cycle.

Function
REQ-013 The block SHALL contain a 16 x 32-bit circular buffer buf, a 6-bit counter t, and a state register with states LOAD and EMIT.
REQ-014 In LOAD: in_ready = 1, out_valid = 0; on in_valid && in_ready, buf[t[3:0]] <= in_data and t <= t + 1.
REQ-015 Acceptance of the 16th word (t == 15) SHALL move the state to EMIT with t <= 0.
REQ-016 In EMIT: in_ready = 0, out_valid = 1, out_idx = t, out_last = (t == 63).
REQ-017 For t < 16, out_data SHALL equal buf[t[3:0]] (pass-through of M[t]).
REQ-018 For t >= 16, out_data SHALL equal sig1(buf[(t-2)&15]) + buf[(t-7)&15] + sig0(buf[(t-15)&15]) + buf[t&15], with addition mod 2^32.
REQ-019 sig0(x) SHALL equal ROR(x,7) ^ ROR(x,18) ^ SHR(x,3); sig1(x) SHALL equal ROR(x,17) ^ ROR(x,19) ^ SHR(x,10).
REQ-020 On the out_valid && out_ready handshake with t >= 16, the computed word SHALL be written to buf[t[3:0]], overwriting W[t-16], and t <= t + 1.
REQ-021 On a handshake with t < 16, t <= t + 1 and the buffer SHALL be unchanged.
REQ-022 The handshake at t == 63 SHALL return the state to LOAD with t <= 0; the next block's words MAY be accepted on the following cycle.
REQ-023 When out_ready is low, out_data, out_idx and the state SHALL hold stable; out_data is combinational from registered state.
REQ-024 Throughput SHALL be one word per cycle in both states; a full block takes 16 load cycles plus 64 emit cycles minimum.
REQ-025 flush SHALL take priority over every handshake: state <= LOAD, t <= 0, in_ready = 1 on the next cycle; buffer contents are don't-care.
REQ-026 in_valid during EMIT SHALL be ignored (in_ready = 0); out_ready during LOAD SHALL be ignored.

Reset
REQ-027 Asserting g_resetn low SHALL immediately force state = LOAD and t = 0, so that out_valid = 0, out_last = 0, out_idx = 0 and in_ready = 1 while reset is held.
REQ-028 The buffer SHALL NOT be reset; out_data is don't-care while out_valid = 0.
REQ-029 Reset asserted mid-LOAD or mid-EMIT SHALL discard the partial block; no stale out_valid SHALL follow deassertion.

Structure
REQ-030 Shared package riscv_crypto_sha256_pkg SHALL hold the state enumeration (LOAD, EMIT), SHA256_WORDS = 16, SHA256_ROUNDS = 64 and the rotate amounts.
REQ-031 A single combinational sub-module riscv_crypto_sha256_sigma SHALL compute sig0 and sig1 from two 32-bit inputs; it is instantiated once.
REQ-032 There SHALL be no other sub-modules; the buffer SHALL be flops, not an inferred RAM, because four read ports are required.

Verification
REQ-033 FIPS 180-4 "abc" block: load W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018 -> out W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405; 64 outputs total; out_last only at idx 63.
REQ-034 Load 16 words with out_ready held high -> out_idx runs 0..63 on consecutive cycles, first 16 outputs equal the inputs, then in_ready = 1 the cycle after idx 63.
REQ-035 Random out_ready back-pressure on the "abc" block -> identical 64-word sequence to REQ-033 as compared against a reference model; out_data stable whenever stalled.
REQ-036 Assert flush at t = 30 in EMIT, then reload the "abc" block -> next W16 = 0x61626380 and no residue from the aborted block.
REQ-037 Pulse g_resetn low asynchronously mid-LOAD (after 7 words) -> out_valid = 0 and in_ready = 1 immediately; 16 fresh words then produce a correct schedule.
REQ-038 Two back-to-back blocks with in_valid held high -> no words are accepted during EMIT, and the second block's W16..W63 match the reference model.

Source files
------------

// File: rtl/riscv_crypto_sha256_pkg.sv
// rtl/riscv_crypto_sha256_pkg.sv - shared SHA-256 schedule types, sizes and rotate amounts
package riscv_crypto_sha256_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int unsigned SHA256_WORDS  = 16;
    localparam int unsigned SHA256_ROUNDS = 64;

    localparam int unsigned SIG0_ROR_A = 7;
    localparam int unsigned SIG0_ROR_B = 18;
    localparam int unsigned SIG0_SHR   = 3;
    localparam int unsigned SIG1_ROR_A = 17;
    localparam int unsigned SIG1_ROR_B = 19;
    localparam int unsigned SIG1_SHR   = 10;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/riscv_crypto_sha256_msched_if.sv
// rtl/riscv_crypto_sha256_msched_if.sv - message-word input and schedule-word output streams
interface riscv_crypto_sha256_msched_if;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/riscv_crypto_sha256_sigma.sv
// rtl/riscv_crypto_sha256_sigma.sv - SHA-256 small sigma functions sig0/sig1
module riscv_crypto_sha256_sigma
    import riscv_crypto_sha256_pkg::*;
(
    input  logic [31:0] i_x0,
    input  logic [31:0] i_x1,
    output logic [31:0] o_sig0,
    output logic [31:0] o_sig1
);

    assign o_sig0 = ror32(i_x0, SIG0_ROR_A) ^ ror32(i_x0, SIG0_ROR_B) ^ (i_x0 >> SIG0_SHR);
    assign o_sig1 = ror32(i_x1, SIG1_ROR_A) ^ ror32(i_x1, SIG1_ROR_B) ^ (i_x1 >> SIG1_SHR);

endmodule

// File: rtl/riscv_crypto_sha256_msched.sv
// rtl/riscv_crypto_sha256_msched.sv - SHA-256 message schedule: loads M[0..15], streams W[0..63]
module riscv_crypto_sha256_msched
    import riscv_crypto_sha256_pkg::*;
(
    input  logic                        g_clk,
    input  logic                        g_resetn,
    input  logic                        flush,
    riscv_crypto_sha256_msched_if.slave bus
);

    state_t      r_state;
    logic [5:0]  r_t;
    logic [31:0] r_buf [SHA256_WORDS];

    logic [3:0]  w_i0;
    logic [3:0]  w_im2;
    logic [3:0]  w_im7;
    logic [3:0]  w_im15;
    logic [31:0] w_sig0;
    logic [31:0] w_sig1;
    logic [31:0] w_next;
    logic        w_expand;
    logic        w_load_hs;
    logic        w_emit_hs;
    logic        w_buf_we;
    logic [31:0] w_buf_wd;

    // Circular-buffer taps for W[t-16], W[t-2], W[t-7], W[t-15]; wrap is free in 4 bits.
    assign w_i0   = r_t[3:0];
    assign w_im2  = r_t[3:0] - 4'd2;
    assign w_im7  = r_t[3:0] - 4'd7;
    assign w_im15 = r_t[3:0] - 4'd15;

    riscv_crypto_sha256_sigma u_sigma (
        .i_x0   (r_buf[w_im15]),
        .i_x1   (r_buf[w_im2]),
        .o_sig0 (w_sig0),
        .o_sig1 (w_sig1)
    );

    assign w_next   = w_sig1 + r_buf[w_im7] + w_sig0 + r_buf[w_i0];
    assign w_expand = (r_t[5:4] != 2'b00);

    assign bus.in_ready  = (r_state == LOAD);
    assign bus.out_valid = (r_state == EMIT);
    assign bus.out_idx   = r_t;
    assign bus.out_last  = (r_state == EMIT) && (r_t == 6'(SHA256_ROUNDS - 1));
    assign bus.out_data  = w_expand ? w_next : r_buf[w_i0];

    assign w_load_hs = (r_state == LOAD) && bus.in_valid;
    assign w_emit_hs = (r_state == EMIT) && bus.out_ready;
    assign w_buf_we  = !flush && (w_load_hs || (w_emit_hs && w_expand));
    assign w_buf_wd  = (r_state == LOAD) ? bus.in_data : w_next;

    // Buffer is deliberately unreset flops: four simultaneous read ports rule out a RAM.
    always_ff @(posedge g_clk) begin
        if (w_buf_we) begin
            r_buf[w_i0] <= w_buf_wd;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= LOAD;
            r_t     <= 6'd0;
        end else if (flush) begin
            r_state <= LOAD;
            r_t     <= 6'd0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (r_t == 6'(SHA256_WORDS - 1)) begin
                            r_state <= EMIT;
                            r_t     <= 6'd0;
                        end else begin
                            r_t     <= r_t + 6'd1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (r_t == 6'(SHA256_ROUNDS - 1)) begin
                            r_state <= LOAD;
                            r_t     <= 6'd0;
                        end else begin
                            r_t     <= r_t + 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_t     <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_crypto_sha256_msched.sv
// tb/tb_riscv_crypto_sha256_msched.sv - directed and randomized checks of the SHA-256 message schedule
module tb_riscv_crypto_sha256_msched;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sch_t [64];

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b1;
    logic flush    = 1'b0;

    always #5 g_clk = ~g_clk;

    riscv_crypto_sha256_msched_if bus ();

    riscv_crypto_sha256_msched dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] abc_w [3];
    blk_t abc_blk, blk_a, blk_b, blk_c;
    sch_t sch_abc, sch_a, sch_b, sch_c;
    int   cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook 64-entry expansion, no circular buffer.
    task automatic build(input blk_t m, output sch_t w);
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
    endtask

    task automatic rand_blk(output blk_t m);
        for (int i = 0; i < 16; i++) m[i] = $urandom;
    endtask

    task automatic load_block(input blk_t m, input int n, input bit gaps, input bit keep);
        logic acc;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'($urandom);
                @(posedge g_clk); #1;
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = m[i];
            bus.out_ready = 1'($urandom);
            acc = 1'b0;
            for (int c = 0; c < 50 && !acc; c++) begin
                @(negedge g_clk);
                chk("load_out_valid", 64'(bus.out_valid), 64'd0);
                acc = bus.in_ready;
                @(posedge g_clk); #1;
            end
            if (!acc) begin
                chk("load_timeout", 64'(acc), 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain(input sch_t w, input int stop, input bit bp, input bit abc, output int cycles);
        int          k;
        logic        stalled;
        logic        take;
        logic [31:0] prev;
        k = 0; stalled = 1'b0; prev = '0; cycles = 0;
        while (k < stop && cycles < 2000) begin
            bus.out_ready = bp ? 1'($urandom) : 1'b1;
            @(negedge g_clk);
            cycles++;
            chk("out_valid",    64'(bus.out_valid), 64'd1);
            chk("in_ready_emit", 64'(bus.in_ready), 64'd0);
            chk("out_idx",      64'(bus.out_idx),  64'(k));
            chk("out_data",     64'(bus.out_data), 64'(w[k]));
            chk("out_last",     64'(bus.out_last), 64'(k == 63));
            if (stalled) chk("stall_stable", 64'(bus.out_data), 64'(prev));
            if (abc && k >= 16 && k <= 18) chk("abc_fips", 64'(bus.out_data), 64'(abc_w[k-16]));
            take = bus.out_valid && bus.out_ready;
            prev = bus.out_data;
            @(posedge g_clk); #1;
            if (take) k++;
            stalled = !take;
        end
        chk("drain_count", 64'(k), 64'(stop));
        if (stop == 64) begin
            chk("in_ready_after_last",  64'(bus.in_ready),  64'd1);
            chk("out_valid_after_last", 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        abc_w[0] = 32'h61626380;
        abc_w[1] = 32'h000F0000;
        abc_w[2] = 32'h7DA86405;
        for (int i = 0; i < 16; i++) abc_blk[i] = 32'h0;
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        build(abc_blk, sch_abc);

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #1 g_resetn = 1'b0;
        #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_idx",   64'(bus.out_idx),   64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        repeat (3) @(posedge g_clk);
        @(negedge g_clk) g_resetn = 1'b1;
        @(posedge g_clk); #1;

        // Full-rate block: 64 consecutive outputs, first 16 pass through
        rand_blk(blk_a);
        build(blk_a, sch_a);
        load_block(blk_a, 16, 1'b0, 1'b0);
        drain(sch_a, 64, 1'b0, 1'b0, cyc);
        chk("full_rate_cycles", 64'(cyc), 64'd64);

        // FIPS "abc" block, full rate then with random back-pressure
        load_block(abc_blk, 16, 1'b1, 1'b0);
        drain(sch_abc, 64, 1'b0, 1'b1, cyc);
        load_block(abc_blk, 16, 1'b1, 1'b0);
        drain(sch_abc, 64, 1'b1, 1'b1, cyc);

        // Flush at t = 30 of a random block, then reload "abc"
        rand_blk(blk_b);
        build(blk_b, sch_b);
        load_block(blk_b, 16, 1'b0, 1'b0);
        drain(sch_b, 30, 1'b0, 1'b0, cyc);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge g_clk); #1;
        flush = 1'b0;
        chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_out_idx",   64'(bus.out_idx),   64'd0);
        load_block(abc_blk, 16, 1'b0, 1'b0);
        drain(sch_abc, 64, 1'b1, 1'b1, cyc);

        // Asynchronous reset after 7 loaded words
        rand_blk(blk_c);
        load_block(blk_c, 7, 1'b0, 1'b0);
        #2 g_resetn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("arst_out_idx",   64'(bus.out_idx),   64'd0);
        @(posedge g_clk);
        #3 g_resetn = 1'b1;
        @(posedge g_clk); #1;
        chk("arst_no_stale_valid", 64'(bus.out_valid), 64'd0);
        rand_blk(blk_c);
        build(blk_c, sch_c);
        load_block(blk_c, 16, 1'b1, 1'b0);
        drain(sch_c, 64, 1'b1, 1'b0, cyc);

        // Back-to-back blocks with in_valid held high through EMIT
        rand_blk(blk_a);
        build(blk_a, sch_a);
        rand_blk(blk_b);
        build(blk_b, sch_b);
        load_block(blk_a, 16, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = blk_b[0];
        drain(sch_a, 64, 1'b0, 1'b0, cyc);
        load_block(blk_b, 16, 1'b0, 1'b0);
        drain(sch_b, 64, 1'b1, 1'b0, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
